// File: rtl/mdp3_book_builder_pkg.sv
// Shared types for the MDP3 book builder: entry decode enums, error codes,
// book level record and controller state.
package mdp3_pkg;

  localparam int PRICE_W = 64;
  localparam int QTY_W   = 16;
  localparam int ORD_W   = 8;

  typedef enum logic [1:0] {
    ACT_NEW    = 2'd0,
    ACT_CHANGE = 2'd1,
    ACT_DELETE = 2'd2
  } act_e;

  typedef enum logic [1:0] {
    ET_BID   = 2'd0,
    ET_OFFER = 2'd1
  } entry_type_e;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_DUP_NEW    = 3'd1;
  localparam logic [2:0] ERR_NOT_FOUND  = 3'd2;
  localparam logic [2:0] ERR_BAD_ACTION = 3'd3;
  localparam logic [2:0] ERR_BAD_TYPE   = 3'd4;

  typedef struct packed {
    logic               valid;
    logic [PRICE_W-1:0] px;
    logic [QTY_W-1:0]   qty;
    logic [ORD_W-1:0]   ord;
  } level_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMP,
    S_APPLY
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_NEW,
    OP_CHANGE,
    OP_DELETE
  } op_e;

endpackage

// File: rtl/mdp3_book_builder_if.sv
// Entry handshake from the parser plus the top-of-book publication bus.
interface mdp3_book_builder_if;

  logic                        in_valid;
  logic                        in_ready;
  logic [1:0]                  in_action;
  logic [1:0]                  in_entry_type;
  logic [mdp3_pkg::PRICE_W-1:0] in_price;
  logic [mdp3_pkg::QTY_W-1:0]   in_qty;
  logic [mdp3_pkg::ORD_W-1:0]   in_num_orders;

  logic                        upd_valid;
  logic [mdp3_pkg::PRICE_W-1:0] bid_px;
  logic [mdp3_pkg::QTY_W-1:0]   bid_qty;
  logic [mdp3_pkg::ORD_W-1:0]   bid_ord;
  logic [mdp3_pkg::PRICE_W-1:0] ask_px;
  logic [mdp3_pkg::QTY_W-1:0]   ask_qty;
  logic [mdp3_pkg::ORD_W-1:0]   ask_ord;
  logic [3:0]                  bid_cnt;
  logic [3:0]                  ask_cnt;
  logic                        err_valid;
  logic [2:0]                  err_code;

  modport slave (
    input  in_valid, in_action, in_entry_type, in_price, in_qty, in_num_orders,
    output in_ready, upd_valid, bid_px, bid_qty, bid_ord, ask_px, ask_qty, ask_ord,
           bid_cnt, ask_cnt, err_valid, err_code
  );

  modport master (
    output in_valid, in_action, in_entry_type, in_price, in_qty, in_num_orders,
    input  in_ready, upd_valid, bid_px, bid_qty, bid_ord, ask_px, ask_qty, ask_ord,
           bid_cnt, ask_cnt, err_valid, err_code
  );

endinterface

// File: rtl/mdp3_book_builder_side.sv
// One side of the book: DEPTH price-sorted levels, registered compare vectors
// and the insert / overwrite / remove shifting.
module mdp3_book_side
  import mdp3_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter bit IS_BID = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmp_en,
  input  op_e                op,
  input  logic [PRICE_W-1:0] px,
  input  logic [QTY_W-1:0]   qty,
  input  logic [ORD_W-1:0]   ord,
  output logic               found,
  output logic [PRICE_W-1:0] best_px,
  output logic [QTY_W-1:0]   best_qty,
  output logic [ORD_W-1:0]   best_ord,
  output logic [3:0]         cnt
);

  level_t           lv    [DEPTH];
  level_t           lv_n  [DEPTH];
  level_t           lv_dn [DEPTH];
  level_t           lv_up [DEPTH];
  level_t           new_lv;
  logic [DEPTH-1:0] match_q;
  logic [DEPTH-1:0] better_q;
  logic [DEPTH-1:0] prev_better;
  logic [3:0]       cnt_n;
  logic             del_hit;

  // Valid levels are packed at the front and sorted, so better_q is a prefix
  // and the insert slot is the first non-better slot.
  assign prev_better = {better_q[DEPTH-2:0], 1'b1};

  always_comb begin
    lv_dn[0] = '0;
    lv_up[DEPTH-1] = '0;
    for (int i = 1; i < DEPTH; i++) lv_dn[i] = lv[i-1];
    for (int i = 0; i < DEPTH - 1; i++) lv_up[i] = lv[i+1];
  end

  always_comb begin
    new_lv  = '{valid: 1'b1, px: px, qty: qty, ord: ord};
    del_hit = 1'b0;
    cnt_n   = '0;
    for (int i = 0; i < DEPTH; i++) lv_n[i] = lv[i];
    case (op)
      OP_NEW: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!better_q[i]) lv_n[i] = prev_better[i] ? new_lv : lv_dn[i];
        end
      end
      OP_CHANGE: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (match_q[i]) begin
            lv_n[i].qty = qty;
            lv_n[i].ord = ord;
          end
        end
      end
      OP_DELETE: begin
        for (int i = 0; i < DEPTH; i++) begin
          del_hit = del_hit | match_q[i];
          if (del_hit) lv_n[i] = lv_up[i];
        end
      end
      default: ;
    endcase
    for (int i = 0; i < DEPTH; i++) cnt_n = cnt_n + 4'(lv_n[i].valid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      match_q  <= '0;
      better_q <= '0;
      cnt      <= '0;
      for (int i = 0; i < DEPTH; i++) lv[i] <= '0;
    end else begin
      if (cmp_en) begin
        for (int i = 0; i < DEPTH; i++) begin
          match_q[i]  <= lv[i].valid && (lv[i].px == px);
          better_q[i] <= lv[i].valid && (IS_BID ? (lv[i].px > px) : (lv[i].px < px));
        end
      end
      if (op != OP_NONE) begin
        for (int i = 0; i < DEPTH; i++) lv[i] <= lv_n[i];
        cnt <= cnt_n;
      end
    end
  end

  // Invalid slots are always all-zero, so an empty side reads 0 here.
  assign found    = |match_q;
  assign best_px  = lv[0].px;
  assign best_qty = lv[0].qty;
  assign best_ord = lv[0].ord;

endmodule

// File: rtl/mdp3_book_builder.sv
// MDP3 incremental-refresh book builder: latches one entry, compares it against
// the addressed side, applies it, and publishes top-of-book for both sides.
module mdp3_book_builder
  import mdp3_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  mdp3_book_builder_if.slave bus
);

  // state   | meaning
  // S_IDLE  | waiting for an entry, in_ready high
  // S_CMP   | sides register match / better vectors for the latched price
  // S_APPLY | addressed side updated, pulse and error registered

  state_e             state_q, state_n;
  logic [1:0]         lat_action, lat_type;
  logic [PRICE_W-1:0] lat_px;
  logic [QTY_W-1:0]   lat_qty;
  logic [ORD_W-1:0]   lat_ord;
  logic               accept, cmp_en, apply;
  logic               sel_found, bid_found, ask_found;
  logic [2:0]         err_n, err_code_q;
  logic               upd_valid_q, err_valid_q;
  op_e                op_n, bid_op, ask_op;

  assign accept = bus.in_valid && (state_q == S_IDLE);

  always_comb begin
    state_n = state_q;
    cmp_en  = 1'b0;
    apply   = 1'b0;
    case (state_q)
      S_IDLE:  if (bus.in_valid) state_n = S_CMP;
      S_CMP: begin
        cmp_en  = 1'b1;
        state_n = S_APPLY;
      end
      S_APPLY: begin
        apply   = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Reserved action takes precedence over an unsupported entry type.
  always_comb begin
    err_n     = ERR_NONE;
    op_n      = OP_NONE;
    sel_found = (lat_type == ET_BID) ? bid_found : ask_found;
    if (lat_action == 2'd3) begin
      err_n = ERR_BAD_ACTION;
    end else if (lat_type > ET_OFFER) begin
      err_n = ERR_BAD_TYPE;
    end else if (lat_action == ACT_NEW) begin
      if (sel_found) err_n = ERR_DUP_NEW;
      else           op_n  = OP_NEW;
    end else if (!sel_found) begin
      err_n = ERR_NOT_FOUND;
    end else if (lat_action == ACT_CHANGE && lat_qty != '0) begin
      op_n = OP_CHANGE;
    end else begin
      op_n = OP_DELETE;
    end
    bid_op = (apply && lat_type == ET_BID)   ? op_n : OP_NONE;
    ask_op = (apply && lat_type == ET_OFFER) ? op_n : OP_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_action  <= '0;
      lat_type    <= '0;
      lat_px      <= '0;
      lat_qty     <= '0;
      lat_ord     <= '0;
      upd_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_n;
      upd_valid_q <= apply;
      err_valid_q <= apply && (err_n != ERR_NONE);
      if (apply) err_code_q <= err_n;
      if (accept) begin
        lat_action <= bus.in_action;
        lat_type   <= bus.in_entry_type;
        lat_px     <= bus.in_price;
        lat_qty    <= bus.in_qty;
        lat_ord    <= bus.in_num_orders;
      end
    end
  end

  mdp3_book_side #(.DEPTH(DEPTH), .IS_BID(1'b1)) u_bid (
    .clk      (clk),
    .reset    (reset),
    .cmp_en   (cmp_en),
    .op       (bid_op),
    .px       (lat_px),
    .qty      (lat_qty),
    .ord      (lat_ord),
    .found    (bid_found),
    .best_px  (bus.bid_px),
    .best_qty (bus.bid_qty),
    .best_ord (bus.bid_ord),
    .cnt      (bus.bid_cnt)
  );

  mdp3_book_side #(.DEPTH(DEPTH), .IS_BID(1'b0)) u_ask (
    .clk      (clk),
    .reset    (reset),
    .cmp_en   (cmp_en),
    .op       (ask_op),
    .px       (lat_px),
    .qty      (lat_qty),
    .ord      (lat_ord),
    .found    (ask_found),
    .best_px  (bus.ask_px),
    .best_qty (bus.ask_qty),
    .best_ord (bus.ask_ord),
    .cnt      (bus.ask_cnt)
  );

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.upd_valid = upd_valid_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_mdp3_book_builder.sv
// Self-checking bench for mdp3_book_builder: directed vector table, random
// entries against a queue-based book model, back-to-back and mid-op reset.
module tb_mdp3_book_builder;
  import mdp3_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdp3_book_builder_if bus ();

  mdp3_book_builder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] px;
    logic [15:0] qty;
    logic [7:0]  ord;
  } mlvl_t;

  mlvl_t mb[$];
  mlvl_t ma[$];

  typedef struct {
    int act, et, px, qty, ord, err;
    int bpx, bqty, bcnt, apx, aqty, aord, acnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Book model: sorted queues, insert by scanning, truncate to DEPTH.
  task automatic model_step(input int act, input int et, input logic [63:0] px,
                            input logic [15:0] qty, input logic [7:0] ord, output int err);
    mlvl_t q[$];
    mlvl_t n;
    int idx;
    int pos;
    bit placed;
    err = 0;
    if (act == 3) begin err = 3; return; end
    if (et > 1)   begin err = 4; return; end
    if (et == 0) q = mb; else q = ma;
    idx = -1;
    foreach (q[i]) if (q[i].px == px) idx = i;
    if (act == 0) begin
      if (idx >= 0) err = 1;
      else begin
        n.px = px; n.qty = qty; n.ord = ord;
        pos = q.size();
        placed = 1'b0;
        foreach (q[i]) begin
          if (!placed && ((et == 0) ? (px > q[i].px) : (px < q[i].px))) begin
            pos = i;
            placed = 1'b1;
          end
        end
        q.insert(pos, n);
        if (q.size() > DEPTH) void'(q.pop_back());
      end
    end else begin
      if (idx < 0) err = 2;
      else if (act == 1 && qty != 0) begin
        n = q[idx]; n.qty = qty; n.ord = ord; q[idx] = n;
      end else q.delete(idx);
    end
    if (et == 0) mb = q; else ma = q;
  endtask

  task automatic compare_all(input string tag, input int err);
    mlvl_t b, a;
    b = '{0, 0, 0};
    a = '{0, 0, 0};
    if (mb.size() > 0) b = mb[0];
    if (ma.size() > 0) a = ma[0];
    chk({tag, " err_valid"}, 64'(bus.err_valid), 64'(err != 0));
    chk({tag, " err_code"}, 64'(bus.err_code), 64'(err));
    chk({tag, " bid_px"}, bus.bid_px, b.px);
    chk({tag, " bid_qty"}, 64'(bus.bid_qty), 64'(b.qty));
    chk({tag, " bid_ord"}, 64'(bus.bid_ord), 64'(b.ord));
    chk({tag, " bid_cnt"}, 64'(bus.bid_cnt), 64'(mb.size()));
    chk({tag, " ask_px"}, bus.ask_px, a.px);
    chk({tag, " ask_qty"}, 64'(bus.ask_qty), 64'(a.qty));
    chk({tag, " ask_ord"}, 64'(bus.ask_ord), 64'(a.ord));
    chk({tag, " ask_cnt"}, 64'(bus.ask_cnt), 64'(ma.size()));
  endtask

  // Drive one entry and return how many edges after the accept edge upd_valid appeared.
  task automatic send(input int a, input int t, input logic [63:0] px,
                      input logic [15:0] q, input logic [7:0] o, output int lat);
    int w;
    lat = -1;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid      = 1'b1;
    bus.in_action     = 2'(a);
    bus.in_entry_type = 2'(t);
    bus.in_price      = px;
    bus.in_qty        = q;
    bus.in_num_orders = o;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.upd_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mb.delete();
    ma.delete();
  endtask

  function automatic vec_t mk(int a, int t, int px, int q, int o, int e,
                              int bp, int bq, int bc, int ap, int aq, int ao, int ac);
    vec_t v;
    v.act = a; v.et = t; v.px = px; v.qty = q; v.ord = o; v.err = e;
    v.bpx = bp; v.bqty = bq; v.bcnt = bc;
    v.apx = ap; v.aqty = aq; v.aord = ao; v.acnt = ac;
    return v;
  endfunction

  initial begin
    int lat, err, npulse, a, t;
    logic [11:0] ready_bits;
    logic any_upd;

    bus.in_valid = 1'b0; bus.in_action = '0; bus.in_entry_type = '0;
    bus.in_price = '0; bus.in_qty = '0; bus.in_num_orders = '0;

    //      act et  px  qty ord err  bpx bqty bcnt  apx aqty aord acnt
    vecs.push_back(mk(0, 0, 100, 10, 1, 0, 100, 10, 1,   0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 102,  5, 2, 0, 102,  5, 2,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 105,  1, 1, 0, 102,  5, 2, 105, 1, 1, 1));
    vecs.push_back(mk(0, 1, 103,  2, 2, 0, 102,  5, 2, 103, 2, 2, 2));
    vecs.push_back(mk(0, 1, 104,  3, 3, 0, 102,  5, 2, 103, 2, 2, 3));
    vecs.push_back(mk(0, 1, 106,  4, 4, 0, 102,  5, 2, 103, 2, 2, 4));
    vecs.push_back(mk(0, 1, 107,  5, 5, 0, 102,  5, 2, 103, 2, 2, 4));
    vecs.push_back(mk(0, 1, 101,  7, 7, 0, 102,  5, 2, 101, 7, 7, 4));
    vecs.push_back(mk(2, 1, 106,  0, 0, 2, 102,  5, 2, 101, 7, 7, 4));
    vecs.push_back(mk(1, 0, 102,  0, 0, 0, 100, 10, 1, 101, 7, 7, 4));
    vecs.push_back(mk(1, 0,  99,  3, 3, 2, 100, 10, 1, 101, 7, 7, 4));
    vecs.push_back(mk(0, 0, 100, 10, 1, 1, 100, 10, 1, 101, 7, 7, 4));
    vecs.push_back(mk(3, 0, 100,  1, 1, 3, 100, 10, 1, 101, 7, 7, 4));
    vecs.push_back(mk(0, 2,  50,  1, 1, 4, 100, 10, 1, 101, 7, 7, 4));
    vecs.push_back(mk(1, 1, 101,  9, 3, 0, 100, 10, 1, 101, 9, 3, 4));
    vecs.push_back(mk(2, 1, 101,  0, 0, 0, 100, 10, 1, 103, 2, 2, 3));
    vecs.push_back(mk(2, 0, 100,  0, 0, 0,   0,  0, 0, 103, 2, 2, 3));

    do_reset();
    chk("reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("reset upd_valid", 64'(bus.upd_valid), 64'd0);
    chk("reset err_valid", 64'(bus.err_valid), 64'd0);
    chk("reset err_code", 64'(bus.err_code), 64'd0);
    chk("reset bid_px", bus.bid_px, 64'd0);
    chk("reset ask_px", bus.ask_px, 64'd0);
    chk("reset bid_cnt", 64'(bus.bid_cnt), 64'd0);
    chk("reset ask_cnt", 64'(bus.ask_cnt), 64'd0);

    foreach (vecs[k]) begin
      send(vecs[k].act, vecs[k].et, 64'(vecs[k].px), 16'(vecs[k].qty), 8'(vecs[k].ord), lat);
      model_step(vecs[k].act, vecs[k].et, 64'(vecs[k].px), 16'(vecs[k].qty), 8'(vecs[k].ord), err);
      chk($sformatf("vec%0d latency", k), 64'(lat), 64'd2);
      chk($sformatf("vec%0d err_valid", k), 64'(bus.err_valid), 64'(vecs[k].err != 0));
      chk($sformatf("vec%0d err_code", k), 64'(bus.err_code), 64'(vecs[k].err));
      chk($sformatf("vec%0d bid_px", k), bus.bid_px, 64'(vecs[k].bpx));
      chk($sformatf("vec%0d bid_qty", k), 64'(bus.bid_qty), 64'(vecs[k].bqty));
      chk($sformatf("vec%0d bid_cnt", k), 64'(bus.bid_cnt), 64'(vecs[k].bcnt));
      chk($sformatf("vec%0d ask_px", k), bus.ask_px, 64'(vecs[k].apx));
      chk($sformatf("vec%0d ask_qty", k), 64'(bus.ask_qty), 64'(vecs[k].aqty));
      chk($sformatf("vec%0d ask_ord", k), 64'(bus.ask_ord), 64'(vecs[k].aord));
      chk($sformatf("vec%0d ask_cnt", k), 64'(bus.ask_cnt), 64'(vecs[k].acnt));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d upd_one_cycle", k), 64'(bus.upd_valid), 64'd0);
      chk($sformatf("vec%0d err_one_cycle", k), 64'(bus.err_valid), 64'd0);
    end

    // Random entries over a narrow price band to force duplicates, misses and evictions.
    for (int n = 0; n < 250; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      a = (r < 4) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      r = int'($urandom_range(0, 15));
      t = (r == 15) ? int'($urandom_range(2, 3)) : (r & 1);
      begin
        logic [63:0] px;
        logic [15:0] q;
        logic [7:0]  o;
        px = 64'(90 + $urandom_range(0, 15));
        q  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 500));
        o  = 8'($urandom_range(1, 50));
        send(a, t, px, q, o, lat);
        model_step(a, t, px, q, o, err);
      end
      chk($sformatf("rnd%0d latency", n), 64'(lat), 64'd2);
      compare_all($sformatf("rnd%0d", n), err);
    end

    // Held in_valid: one accept every third cycle.
    do_reset();
    bus.in_valid = 1'b1; bus.in_action = 2'd0; bus.in_entry_type = 2'd0;
    bus.in_price = 64'd200; bus.in_qty = 16'd7; bus.in_num_orders = 8'd1;
    npulse = 0;
    ready_bits = '0;
    for (int c = 0; c < 12; c++) begin
      ready_bits[c] = bus.in_ready;
      @(posedge clk);
      #1;
      if (bus.upd_valid) npulse++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) model_step(0, 0, 64'd200, 16'd7, 8'd1, err);
    chk("b2b ready_pattern", 64'(ready_bits), 64'(12'b001001001001));
    chk("b2b upd_pulses", 64'(npulse), 64'd4);
    compare_all("b2b", err);

    // Reset asserted during the CMP cycle of a New.
    send(0, 0, 64'd150, 16'd3, 8'd2, lat);
    model_step(0, 0, 64'd150, 16'd3, 8'd2, err);
    compare_all("pre_rst", err);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_action = 2'd0; bus.in_entry_type = 2'd0;
    bus.in_price = 64'd310; bus.in_qty = 16'd4; bus.in_num_orders = 8'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mb.delete();
    ma.delete();
    any_upd = bus.upd_valid;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      any_upd = any_upd | bus.upd_valid;
    end
    chk("midrst no_upd", 64'(any_upd), 64'd0);
    chk("midrst in_ready", 64'(bus.in_ready), 64'd1);
    compare_all("midrst", 0);
    send(0, 1, 64'd120, 16'd8, 8'd3, lat);
    model_step(0, 1, 64'd120, 16'd8, 8'd3, err);
    chk("post_rst latency", 64'(lat), 64'd2);
    compare_all("post_rst", err);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
